// File: rtl/prng_lfsr_gen_pkg.sv
// Shared constants for the LFSR generator: mode encoding, maximal-length tap masks and default seeds.
package prng_lfsr_gen_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } prng_mode_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [23:0] TAPS_W24 = 24'hE10000;
  localparam logic [31:0] TAPS_W32 = 32'hA3000000;

  localparam logic [7:0]  SEED_W8  = 8'hA5;
  localparam logic [15:0] SEED_W16 = 16'hACE1;
  localparam logic [23:0] SEED_W24 = 24'hACE1A5;
  localparam logic [31:0] SEED_W32 = 32'hACE1ACE1;

endpackage

// File: rtl/prng_lfsr_gen_step.sv
// One combinational LFSR shift in either Fibonacci or Galois form, sharing a single tap mask.
module prng_step
  import prng_lfsr_gen_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W16
) (
  input  logic [WIDTH-1:0] state_i,
  input  prng_mode_e       mode_i,
  output logic [WIDTH-1:0] state_o
);

  always_comb begin
    state_o = state_i;
    if (mode_i == MODE_GAL) begin
      state_o = {1'b0, state_i[WIDTH-1:1]} ^ ({WIDTH{state_i[0]}} & TAPS);
    end else begin
      state_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
    end
  end

endmodule

// File: rtl/prng_lfsr_gen.sv
// Parametrised LFSR random-word source with seed load, lockup recovery and a valid/ready output.
// Optional period checker enabled by defining PRNG_PERIOD_CHK_EN.
module prng_lfsr_gen
  import prng_lfsr_gen_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED  = SEED_W16,
  parameter int unsigned       OUT_W = 8,
  parameter int unsigned       STEPS = 1,
  parameter int unsigned       CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             seed_err,
  output logic             lockup,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [OUT_W-1:0] rnd_data,
  output logic [CNT_W-1:0] draw_cnt,
  output logic             period_wrap,
  output logic [CNT_W-1:0] period_len
);

  // A zero seed would lock the register, so it is silently promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seed_err_q, seed_err_d;
  logic             lockup_q, lockup_d;
  logic             state_zero;
  logic             advance;
  prng_mode_e       mode_e;
  logic [WIDTH-1:0] chain [STEPS+1];

  assign mode_e     = prng_mode_e'(mode);
  assign state_zero = (state_q == '0);
  assign rnd_valid  = en & ~seed_load & ~state_zero;
  assign advance    = rnd_valid & rnd_ready;
  assign rnd_data   = state_q[OUT_W-1:0];
  assign draw_cnt   = cnt_q;
  assign seed_err   = seed_err_q;
  assign lockup     = lockup_q;

  assign chain[0] = state_q;
  for (genvar s = 0; s < STEPS; s++) begin : g_step
    prng_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .state_i (chain[s]),
      .mode_i  (mode_e),
      .state_o (chain[s+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seed_err_d = 1'b0;
    lockup_d   = 1'b0;
    if (seed_load) begin
      cnt_d = '0;
      if (seed_in == '0) begin
        state_d    = SEED_EFF;
        seed_err_d = 1'b1;
      end else begin
        state_d = seed_in;
      end
    end else if (state_zero) begin
      state_d  = SEED_EFF;
      lockup_d = 1'b1;
    end else if (advance) begin
      state_d = chain[STEPS];
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEED_EFF;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seed_err_q <= seed_err_d;
      lockup_q   <= lockup_d;
    end
  end

`ifdef PRNG_PERIOD_CHK_EN
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic             wrap_q, wrap_d;

  // Any event that re-bases the sequence also re-bases the reference point.
  always_comb begin
    ref_d     = ref_q;
    per_cnt_d = per_cnt_q;
    plen_d    = plen_q;
    wrap_d    = 1'b0;
    if (seed_load || state_zero) begin
      ref_d     = state_d;
      per_cnt_d = '0;
    end else if (advance) begin
      if (chain[STEPS] == ref_q) begin
        wrap_d    = 1'b1;
        plen_d    = per_cnt_q + CNT_W'(1);
        per_cnt_d = '0;
      end else begin
        per_cnt_d = per_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q     <= SEED_EFF;
      per_cnt_q <= '0;
      plen_q    <= '0;
      wrap_q    <= 1'b0;
    end else begin
      ref_q     <= ref_d;
      per_cnt_q <= per_cnt_d;
      plen_q    <= plen_d;
      wrap_q    <= wrap_d;
    end
  end

  assign period_wrap = wrap_q;
  assign period_len  = plen_q;
`else
  assign period_wrap = 1'b0;
  assign period_len  = '0;
`endif

endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Bench for prng_lfsr_gen: directed table, hand sequences and a randomized run against a reference model.
module tb_prng_lfsr_gen;
  localparam logic [7:0] TP = 8'hB8;
  localparam logic [7:0] SD = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic en, mode, sl, rdy, err, lk, vld, pw;
  logic [7:0]  sin, data;
  logic [31:0] cnt, pl;
  // zero-tap instance for lockup
  logic z_en, z_mode, z_sl, z_rdy, z_err, z_lk, z_vld, z_pw;
  logic [7:0]  z_sin, z_data;
  logic [31:0] z_cnt, z_pl;
  // 4-bit counter, three shifts per draw
  logic c_en, c_mode, c_sl, c_rdy, c_err, c_lk, c_vld, c_pw;
  logic [7:0] c_sin, c_data;
  logic [3:0] c_cnt, c_pl;

  prng_lfsr_gen #(.WIDTH(8), .TAPS(TP), .SEED(SD), .OUT_W(8), .STEPS(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .seed_load(sl), .seed_in(sin),
    .seed_err(err), .lockup(lk), .rnd_valid(vld), .rnd_ready(rdy), .rnd_data(data),
    .draw_cnt(cnt), .period_wrap(pw), .period_len(pl));

  prng_lfsr_gen #(.WIDTH(8), .TAPS(8'h00), .SEED(SD), .OUT_W(8), .STEPS(1), .CNT_W(32)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(z_en), .mode(z_mode), .seed_load(z_sl), .seed_in(z_sin),
    .seed_err(z_err), .lockup(z_lk), .rnd_valid(z_vld), .rnd_ready(z_rdy), .rnd_data(z_data),
    .draw_cnt(z_cnt), .period_wrap(z_pw), .period_len(z_pl));

  prng_lfsr_gen #(.WIDTH(8), .TAPS(TP), .SEED(SD), .OUT_W(8), .STEPS(3), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .mode(c_mode), .seed_load(c_sl), .seed_in(c_sin),
    .seed_err(c_err), .lockup(c_lk), .rnd_valid(c_vld), .rnd_ready(c_rdy), .rnd_data(c_data),
    .draw_cnt(c_cnt), .period_wrap(c_pw), .period_len(c_pl));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference shift: parity feedback into bit 0, or right shift with tap xor when bit 0 falls out.
  function automatic logic [7:0] ref_step(input logic [7:0] s, input bit gal, input logic [7:0] taps);
    int unsigned v;
    v = s;
    if (gal) v = (v / 2) ^ ((v % 2 == 1) ? int'(taps) : 0);
    else     v = ((v * 2) % 256) + ($countones(s & taps) % 2);
    return 8'(v);
  endfunction

  task automatic idle_all();
    en = 0; mode = 0; sl = 0; rdy = 0; sin = '0;
    z_en = 0; z_mode = 0; z_sl = 0; z_rdy = 0; z_sin = '0;
    c_en = 0; c_mode = 0; c_sl = 0; c_rdy = 0; c_sin = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en, mode, sl, rdy;
    logic [7:0] sin;
    bit         e_vld;
    logic [7:0] e_data;
    logic [31:0] e_cnt;
    bit         e_err;
  } vec_t;

  vec_t tbl[9];

  logic [7:0]  m_state;
  logic [31:0] m_cnt;
  bit          m_err, m_vld, found;
  int          n;

  initial begin
    idle_all();
    tbl[0] = '{1, 0, 0, 1, 8'h00, 1, 8'hA5, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 8'h00, 1, 8'h4A, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 8'h00, 0, 8'h4A, 1, 0};
    tbl[3] = '{1, 1, 0, 1, 8'h00, 1, 8'h4A, 1, 0};
    tbl[4] = '{1, 1, 0, 1, 8'h00, 1, 8'h25, 2, 0};
    tbl[5] = '{1, 0, 1, 1, 8'h3C, 0, 8'hAA, 3, 0};
    tbl[6] = '{1, 0, 1, 1, 8'h00, 0, 8'h3C, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 8'h00, 1, 8'hA5, 0, 1};
    tbl[8] = '{1, 0, 0, 0, 8'h00, 1, 8'h4A, 1, 0};

    // reset state
    do_reset();
    #1;
    check("rst_data", data, 8'hA5);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    check("rst_lockup", lk, 0);
    check("rst_valid_en0", vld, 0);
    check("rst_pwrap", pw, 0);
    check("rst_plen", pl, 0);

    // directed table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      en = tbl[i].en; mode = tbl[i].mode; sl = tbl[i].sl; rdy = tbl[i].rdy; sin = tbl[i].sin;
      #1;
      check($sformatf("tbl%0d_valid", i), vld, tbl[i].e_vld);
      check($sformatf("tbl%0d_data", i), data, tbl[i].e_data);
      check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
      check($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      @(posedge clk);
    end

    // Galois first draw from reset
    do_reset();
    @(negedge clk); en = 1; mode = 1; rdy = 1;
    @(posedge clk);
    @(negedge clk); en = 0; #1;
    check("gal_first", data, 8'hEA);
    check("gal_first_cnt", cnt, 1);

    // backpressure, seed load, zero-seed rejection
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); en = 1; rdy = 0; #1;
      check("bp_data", data, 8'hA5);
      check("bp_cnt", cnt, 0);
      @(posedge clk);
    end
    @(negedge clk); sl = 1; sin = 8'h3C; #1;
    check("sl_valid_low", vld, 0);
    @(posedge clk);
    @(negedge clk); sl = 0; #1;
    check("sl_data", data, 8'h3C);
    check("sl_cnt", cnt, 0);
    @(negedge clk); sl = 1; sin = 8'h00;
    @(posedge clk);
    @(negedge clk); sl = 0; #1;
    check("zseed_data", data, 8'hA5);
    check("zseed_err_on", err, 1);
    @(posedge clk);
    @(negedge clk); #1;
    check("zseed_err_off", err, 0);

    // lockup: Galois from 0x01 with no taps reaches zero in one draw
    do_reset();
    @(negedge clk); z_sl = 1; z_sin = 8'h01;
    @(posedge clk);
    @(negedge clk); z_sl = 0; z_en = 1; z_rdy = 1; z_mode = 1; #1;
    check("lk_g_data0", z_data, 8'h01);
    @(posedge clk);
    @(negedge clk); #1;
    check("lk_g_zero", z_data, 8'h00);
    check("lk_g_valid_low", z_vld, 0);
    check("lk_g_pulse_early", z_lk, 0);
    @(posedge clk);
    @(negedge clk); #1;
    check("lk_g_recover", z_data, 8'hA5);
    check("lk_g_pulse", z_lk, 1);
    check("lk_g_cnt", z_cnt, 1);
    @(posedge clk);
    @(negedge clk); #1;
    check("lk_g_pulse_off", z_lk, 0);
    check("lk_g_next", z_data, ref_step(8'hA5, 1'b1, 8'h00));
    // Fibonacci from 0x01 with no taps needs eight draws
    z_en = 0; z_sl = 1; z_sin = 8'h01;
    @(posedge clk);
    @(negedge clk); z_sl = 0; z_en = 1; z_mode = 0;
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    check("lk_f_zero", z_data, 8'h00);
    check("lk_f_cnt", z_cnt, 8);
    @(posedge clk);
    @(negedge clk); z_en = 0; #1;
    check("lk_f_pulse", z_lk, 1);
    check("lk_f_recover", z_data, 8'hA5);

    // 4-bit counter wrap with three shifts per draw
    do_reset();
    @(negedge clk); c_en = 1; c_rdy = 1;
    @(posedge clk);
    @(negedge clk); #1;
    m_state = SD;
    for (int k = 0; k < 3; k++) m_state = ref_step(m_state, 1'b0, TP);
    check("c_step3", c_data, m_state);
    check("c_cnt1", c_cnt, 1);
    repeat (14) @(posedge clk);
    @(negedge clk); #1;
    check("c_cnt15", c_cnt, 15);
    @(posedge clk);
    @(negedge clk); c_en = 0; #1;
    check("c_cnt_wrap", c_cnt, 0);
    m_state = SD;
    for (int k = 0; k < 48; k++) m_state = ref_step(m_state, 1'b0, TP);
    check("c_data16", c_data, m_state);

`ifdef PRNG_PERIOD_CHK_EN
    do_reset();
    @(negedge clk); en = 1; mode = 0; rdy = 1;
    n = 0; found = 0;
    while (n < 300 && !found) begin
      @(posedge clk); #1;
      n++;
      if (pw) found = 1;
    end
    check("per_seen", found, 1);
    check("per_draws", n, 255);
    check("per_len", pl, 255);
    check("per_cnt", cnt, 255);
    @(posedge clk); #1;
    check("per_pulse_off", pw, 0);
    @(negedge clk); en = 0;
`endif

    // randomized run against the model
    do_reset();
    m_state = SD; m_cnt = 0; m_err = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 7) != 0);
      mode = 1'($urandom_range(0, 1));
      rdy  = ($urandom_range(0, 3) != 0);
      sl   = ($urandom_range(0, 19) == 0);
      sin  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      #1;
      m_vld = en && !sl && (m_state != 0);
      check("rnd_valid", vld, m_vld);
      check("rnd_data", data, m_state);
      check("rnd_cnt", cnt, m_cnt);
      check("rnd_err", err, m_err);
      check("rnd_lockup", lk, 0);
`ifndef PRNG_PERIOD_CHK_EN
      check("rnd_pwrap", pw, 0);
      check("rnd_plen", pl, 0);
`endif
      @(posedge clk);
      m_err = 0;
      if (sl) begin
        m_cnt = 0;
        if (sin == 0) begin m_state = SD; m_err = 1; end
        else m_state = sin;
      end else if (m_vld && rdy) begin
        m_state = ref_step(m_state, mode, TP);
        m_cnt++;
      end
    end

    // asynchronous reset in the middle of a cycle
    @(negedge clk); en = 1; rdy = 1; sl = 0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", data, 8'hA5);
    check("async_rst_cnt", cnt, 0);
    check("async_rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1; en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
